trap_status_ctrl: RTL and testbench
===================================

Name: trap_status_ctrl

Overview:
- Trap sequencer and owner of the 20-bit status register, directly upstream of the XSTAT combine stage.
- Drives `status_register` and `trap_mode` into XSTAT and captures XSTAT's `result` back into the status register on commit.
- Saves and restores status across nested traps using a small LIFO save stack.
- Sits in the program-flow group between trap sources (decode/exception logic) and XSTAT.

Parameters:
- WIDTH, 20, status register width (must match XSTAT).
- CAUSE_W, 4, trap cause width; the cause is written into `status[WIDTH-1 -: CAUSE_W]` on entry.
- DEPTH, 4, save-stack entries, which is the maximum trap nesting depth.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trap_req  in  1  trap request, level; the source holds it until trap_ack.
- trap_cause  in  CAUSE_W  cause code, valid while trap_req is high.
- trap_ack  out  1  one-cycle pulse: trap accepted.
- trap_ret  in  1  one-cycle pulse: return from the current trap.
- xstat_commit  in  1  one-cycle pulse: latch xstat_result into status.
- xstat_result  in  WIDTH  result from XSTAT.
- sw_wr_en  in  1  software status write strobe.
- sw_wr_data  in  WIDTH  software write data.
- status_register  out  WIDTH  current status, to XSTAT.
- trap_mode  out  1  high while in ACTIVE, to XSTAT.
- trap_depth  out  $clog2(DEPTH+1)  current nesting level.
- err  out  2  sticky errors: bit0 = overflow, bit1 = underflow.

Behaviour:
- Reset (asynchronous, rst_n low) forces:
  - state = IDLE, status = 0, all stack entries = 0, depth = 0.
  - trap_ack = 0, trap_mode = 0, err = 0.
  - Any operation in flight is abandoned with no partial update.
- All outputs are registered. trap_mode = (state == ACTIVE).
- FSM states: IDLE, ENTER, ACTIVE, RETURN.
- IDLE:
  - If trap_req: go to ENTER.
  - Else if trap_ret: set err[1], stay in IDLE.
  - Else if sw_wr_en: status <= sw_wr_data.
- ENTER (exactly 1 cycle):
  - Push status to stack[depth]; depth <= depth+1.
  - status[WIDTH-1 -: CAUSE_W] <= trap_cause; lower bits are unchanged.
  - trap_ack = 1 in this cycle only.
  - Next state = ACTIVE.
- ACTIVE, priority highest first:
  1. trap_ret: go to RETURN. A concurrent xstat_commit or sw_wr_en is dropped. A concurrent trap_req remains pending, held by the source.
  2. trap_req with depth < DEPTH: go to ENTER (nested trap). A concurrent commit is applied first, so the pushed value includes it.
  3. trap_req with depth == DEPTH: set err[0], no ack, stay in ACTIVE. The request is re-evaluated every cycle.
  4. xstat_commit: status <= xstat_result.
  5. sw_wr_en: status <= sw_wr_data.
- RETURN (exactly 1 cycle):
  - status <= stack[depth-1]; depth <= depth-1.
  - Next state = IDLE if the new depth is 0, else ACTIVE.
- Latency:
  - trap_req sampled in IDLE → trap_ack on the next cycle → trap_mode high one cycle after that.
  - trap_ret → restored status visible 2 cycles later.
- err bits are sticky and are cleared only by reset.
- Stack contents above depth are don't-care, but must never be output.

Test Plan:
- Reset mid-ACTIVE at depth 2:
  - Stimulus: assert rst_n = 0.
  - Response: all outputs 0 in the same cycle, without waiting for a clock; FSM in IDLE after release.
- Single trap:
  - Stimulus: status = 0x00ABC, trap_cause = 0x5, trap_req held.
  - Response: trap_ack pulses one cycle later; trap_mode = 1 a cycle after that; status = 0x50ABC; trap_depth = 1.
- Commit then return:
  - Stimulus: in ACTIVE, xstat_commit with xstat_result = 0x12345; then trap_ret.
  - Response: status = 0x12345 after the commit; status = 0x00ABC and trap_mode = 0 two cycles after trap_ret.
- Nesting and overflow:
  - Stimulus: 4 nested traps with causes 1, 2, 3, 4, then a 5th trap_req.
  - Response: trap_depth = 4; no ack for the 5th; err = 2'b01.
  - Then 4 trap_ret pulses restore status in LIFO order.
- Simultaneous events:
  - Stimulus: trap_ret, xstat_commit and trap_req in the same ACTIVE cycle at depth 1.
  - Response: the commit is dropped; RETURN pops the original value; IDLE is reached; the held trap_req is then acked.
- Underflow and software write:
  - Stimulus: trap_ret in IDLE.
  - Response: err[1] = 1; status unchanged.
  - Stimulus: sw_wr_en with 0xFFFFF in IDLE.
  - Response: status = 0xFFFFF.
  - Stimulus: sw_wr_en in ENTER.
  - Response: the write is ignored.

Source files
------------

// File: rtl/trap_status_ctrl_if.sv
// Trap / status bundle shared between the trap sources, XSTAT and trap_status_ctrl.
// The master side drives requests and XSTAT results; the slave side owns status and the trap FSM.
interface trap_status_ctrl_if #(
    parameter int WIDTH   = 20,
    parameter int CAUSE_W = 4,
    parameter int DEPTH   = 4
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               trap_req;
    logic [CAUSE_W-1:0] trap_cause;
    logic               trap_ack;
    logic               trap_ret;
    logic               xstat_commit;
    logic [WIDTH-1:0]   xstat_result;
    logic               sw_wr_en;
    logic [WIDTH-1:0]   sw_wr_data;
    logic [WIDTH-1:0]   status_register;
    logic               trap_mode;
    logic [DEPTH_W-1:0] trap_depth;
    logic [1:0]         err;

    modport master (
        output trap_req, trap_cause, trap_ret, xstat_commit, xstat_result,
               sw_wr_en, sw_wr_data,
        input  trap_ack, status_register, trap_mode, trap_depth, err
    );

    modport slave (
        input  trap_req, trap_cause, trap_ret, xstat_commit, xstat_result,
               sw_wr_en, sw_wr_data,
        output trap_ack, status_register, trap_mode, trap_depth, err
    );
endinterface

// File: rtl/trap_status_ctrl.sv
// Trap sequencer and owner of the status register feeding XSTAT; nested traps save and
// restore status through a small LIFO whose depth bounds the nesting level.
module trap_status_ctrl #(
    parameter int WIDTH   = 20,
    parameter int CAUSE_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    trap_status_ctrl_if.slave bus
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2,
        RETURN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   status_q, status_d;
    logic [WIDTH-1:0]   stack_q [DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [1:0]         err_q, err_d;
    logic               ack_q, mode_q;
    logic               push_en;

    logic [DEPTH_W-1:0] depth_dec;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic               at_limit;

    assign depth_dec = depth_q - DEPTH_W'(1);
    assign push_idx  = depth_q[IDX_W-1:0];
    assign pop_idx   = depth_dec[IDX_W-1:0];
    assign at_limit  = (depth_q == DEPTH_W'(DEPTH));

    // NOTE: every variable gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        depth_d  = depth_q;
        err_d    = err_q;
        push_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.trap_req) begin
                    state_d = ENTER;
                end else if (bus.trap_ret) begin
                    err_d[1] = 1'b1;
                end else if (bus.sw_wr_en) begin
                    status_d = bus.sw_wr_data;
                end
            end

            ENTER: begin
                push_en                         = 1'b1;
                depth_d                         = depth_q + DEPTH_W'(1);
                status_d[WIDTH-1 -: CAUSE_W]    = bus.trap_cause;
                state_d                         = ACTIVE;
            end

            ACTIVE: begin
                // A return wins over everything; a pending request is simply re-seen later.
                if (bus.trap_ret) begin
                    state_d = RETURN;
                end else if (bus.trap_req && !at_limit) begin
                    if (bus.xstat_commit) status_d = bus.xstat_result;
                    state_d = ENTER;
                end else if (bus.trap_req) begin
                    err_d[0] = 1'b1;
                end else if (bus.xstat_commit) begin
                    status_d = bus.xstat_result;
                end else if (bus.sw_wr_en) begin
                    status_d = bus.sw_wr_data;
                end
            end

            RETURN: begin
                status_d = stack_q[pop_idx];
                depth_d  = depth_dec;
                state_d  = (depth_dec == '0) ? IDLE : ACTIVE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            depth_q  <= '0;
            err_q    <= '0;
            ack_q    <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            status_q <= status_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
            ack_q    <= (state_d == ENTER);
            mode_q   <= (state_d == ACTIVE);
        end
    end

    // NOTE: this small stack is cleared on reset so no stale entry can ever be restored;
    // large RAM-style arrays would normally be left without a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_en) begin
            stack_q[push_idx] <= status_q;
        end
    end

    assign bus.status_register = status_q;
    assign bus.trap_ack        = ack_q;
    assign bus.trap_mode       = mode_q;
    assign bus.trap_depth      = depth_q;
    assign bus.err             = err_q;

endmodule

// File: tb/tb_trap_status_ctrl.sv
// Self-checking bench for trap_status_ctrl: directed scenarios with fixed expectations,
// then randomized traffic compared each cycle against a queue-based reference model.
module tb_trap_status_ctrl;
    localparam int WIDTH   = 20;
    localparam int CAUSE_W = 4;
    localparam int DEPTH   = 4;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    trap_status_ctrl_if #(.WIDTH(WIDTH), .CAUSE_W(CAUSE_W), .DEPTH(DEPTH)) bus ();

    trap_status_ctrl #(.WIDTH(WIDTH), .CAUSE_W(CAUSE_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: saved statuses in a queue, one flag for "trap being accepted"
    // and one for "return being performed"; idle/active follows from the queue size.
    logic [WIDTH-1:0] m_status;
    logic [WIDTH-1:0] m_stack[$];
    bit               m_entering;
    bit               m_returning;
    logic [1:0]       m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_status    = '0;
            m_stack.delete();
            m_entering  = 1'b0;
            m_returning = 1'b0;
            m_err       = '0;
        end else if (m_entering) begin
            m_stack.push_back(m_status);
            m_status[WIDTH-1 -: CAUSE_W] = bus.trap_cause;
            m_entering = 1'b0;
        end else if (m_returning) begin
            m_status    = m_stack.pop_back();
            m_returning = 1'b0;
        end else if (m_stack.size() == 0) begin
            if (bus.trap_req)       m_entering = 1'b1;
            else if (bus.trap_ret)  m_err[1]   = 1'b1;
            else if (bus.sw_wr_en)  m_status   = bus.sw_wr_data;
        end else begin
            if (bus.trap_ret) begin
                m_returning = 1'b1;
            end else if (bus.trap_req && m_stack.size() < DEPTH) begin
                if (bus.xstat_commit) m_status = bus.xstat_result;
                m_entering = 1'b1;
            end else if (bus.trap_req) begin
                m_err[0] = 1'b1;
            end else if (bus.xstat_commit) begin
                m_status = bus.xstat_result;
            end else if (bus.sw_wr_en) begin
                m_status = bus.sw_wr_data;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.trap_req     = 1'b0;
        bus.trap_cause   = '0;
        bus.trap_ret     = 1'b0;
        bus.xstat_commit = 1'b0;
        bus.xstat_result = '0;
        bus.sw_wr_en     = 1'b0;
        bus.sw_wr_data   = '0;
    endtask

    // Raise a request, wait (bounded) for the ack, then settle into the trap.
    task automatic enter_trap(input logic [CAUSE_W-1:0] cause);
        bit got = 1'b0;
        bus.trap_req   = 1'b1;
        bus.trap_cause = cause;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (bus.trap_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            $display("FAIL enter_trap_ack cause=%0h got=no_ack exp=ack_within_8", cause);
            failures++;
        end
        bus.trap_req = 1'b0;
        step();
    endtask

    task automatic leave_trap();
        bus.trap_ret = 1'b1;
        step();
        bus.trap_ret = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #7;
        checks++;
        if (bus.status_register !== '0 || bus.trap_depth !== '0 || bus.trap_mode !== 1'b0 ||
            bus.trap_ack !== 1'b0 || bus.err !== 2'b00) begin
            $display("FAIL reset_initial got=%h/%0d/%b/%b/%b exp=0", bus.status_register,
                     bus.trap_depth, bus.trap_mode, bus.trap_ack, bus.err);
            failures++;
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        enter_trap(4'h1);
        enter_trap(4'h2);
        checks++;
        if (bus.trap_depth !== DEPTH_W'(2) || bus.trap_mode !== 1'b1) begin
            $display("FAIL reset_pre_depth got=%0d/%b exp=2/1", bus.trap_depth, bus.trap_mode);
            failures++;
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.status_register !== '0 || bus.trap_depth !== '0 || bus.trap_mode !== 1'b0 ||
            bus.trap_ack !== 1'b0 || bus.err !== 2'b00) begin
            $display("FAIL reset_async got=%h/%0d/%b/%b/%b exp=0", bus.status_register,
                     bus.trap_depth, bus.trap_mode, bus.trap_ack, bus.err);
            failures++;
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        bus.trap_req   = 1'b1;
        bus.trap_cause = 4'h3;
        step();
        checks++;
        if (bus.trap_ack !== 1'b1 || bus.trap_depth !== '0) begin
            $display("FAIL reset_idle_ack got=%b/%0d exp=1/0", bus.trap_ack, bus.trap_depth);
            failures++;
        end
        bus.trap_req = 1'b0;
        step();
        leave_trap();
    endtask

    task automatic test_single_trap();
        bus.sw_wr_en   = 1'b1;
        bus.sw_wr_data = 20'h00ABC;
        step();
        bus.sw_wr_en = 1'b0;
        checks++;
        if (bus.status_register !== 20'h00ABC) begin
            $display("FAIL single_swwr got=%h exp=00abc", bus.status_register);
            failures++;
        end
        bus.trap_req   = 1'b1;
        bus.trap_cause = 4'h5;
        step();
        checks++;
        if (bus.trap_ack !== 1'b1 || bus.trap_mode !== 1'b0) begin
            $display("FAIL single_ack got=%b/%b exp=1/0", bus.trap_ack, bus.trap_mode);
            failures++;
        end
        bus.trap_req = 1'b0;
        step();
        checks++;
        if (bus.trap_ack !== 1'b0 || bus.trap_mode !== 1'b1 ||
            bus.status_register !== 20'h50ABC || bus.trap_depth !== DEPTH_W'(1)) begin
            $display("FAIL single_active got=%b/%b/%h/%0d exp=0/1/50abc/1", bus.trap_ack,
                     bus.trap_mode, bus.status_register, bus.trap_depth);
            failures++;
        end
    endtask

    task automatic test_commit_return();
        bus.xstat_commit = 1'b1;
        bus.xstat_result = 20'h12345;
        step();
        bus.xstat_commit = 1'b0;
        checks++;
        if (bus.status_register !== 20'h12345) begin
            $display("FAIL commit_status got=%h exp=12345", bus.status_register);
            failures++;
        end
        bus.trap_ret = 1'b1;
        step();
        bus.trap_ret = 1'b0;
        checks++;
        if (bus.trap_mode !== 1'b0 || bus.status_register !== 20'h12345) begin
            $display("FAIL return_first got=%b/%h exp=0/12345", bus.trap_mode, bus.status_register);
            failures++;
        end
        step();
        checks++;
        if (bus.status_register !== 20'h00ABC || bus.trap_mode !== 1'b0 || bus.trap_depth !== '0) begin
            $display("FAIL return_restore got=%h/%b/%0d exp=00abc/0/0", bus.status_register,
                     bus.trap_mode, bus.trap_depth);
            failures++;
        end
    endtask

    task automatic test_nesting_overflow();
        logic [WIDTH-1:0] exp_pop [4] = '{20'h30ABC, 20'h20ABC, 20'h10ABC, 20'h00ABC};
        bit saw_ack = 1'b0;
        for (int c = 1; c <= 4; c++) enter_trap(CAUSE_W'(c));
        checks++;
        if (bus.trap_depth !== DEPTH_W'(4) || bus.status_register !== 20'h40ABC) begin
            $display("FAIL nest_depth got=%0d/%h exp=4/40abc", bus.trap_depth, bus.status_register);
            failures++;
        end
        bus.trap_req   = 1'b1;
        bus.trap_cause = 4'h5;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.trap_ack === 1'b1) saw_ack = 1'b1;
        end
        bus.trap_req = 1'b0;
        checks++;
        if (saw_ack || bus.err !== 2'b01 || bus.trap_depth !== DEPTH_W'(4) || bus.trap_mode !== 1'b1) begin
            $display("FAIL overflow got=ack%b/%b/%0d/%b exp=ack0/01/4/1", saw_ack, bus.err,
                     bus.trap_depth, bus.trap_mode);
            failures++;
        end
        for (int i = 0; i < 4; i++) begin
            leave_trap();
            checks++;
            if (bus.status_register !== exp_pop[i] || bus.trap_depth !== DEPTH_W'(3 - i) ||
                bus.trap_mode !== (i != 3)) begin
                $display("FAIL lifo_pop%0d got=%h/%0d/%b exp=%h/%0d/%b", i, bus.status_register,
                         bus.trap_depth, bus.trap_mode, exp_pop[i], 3 - i, i != 3);
                failures++;
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.sw_wr_en   = 1'b1;
        bus.sw_wr_data = 20'h0F0F0;
        step();
        bus.sw_wr_en = 1'b0;
        enter_trap(4'h6);
        bus.trap_ret     = 1'b1;
        bus.xstat_commit = 1'b1;
        bus.xstat_result = 20'hAAAAA;
        bus.trap_req     = 1'b1;
        bus.trap_cause   = 4'h7;
        step();
        bus.trap_ret     = 1'b0;
        bus.xstat_commit = 1'b0;
        checks++;
        if (bus.status_register !== 20'h6F0F0 || bus.trap_ack !== 1'b0 || bus.trap_mode !== 1'b0) begin
            $display("FAIL simul_drop got=%h/%b/%b exp=6f0f0/0/0", bus.status_register,
                     bus.trap_ack, bus.trap_mode);
            failures++;
        end
        step();
        checks++;
        if (bus.status_register !== 20'h0F0F0 || bus.trap_depth !== '0 || bus.trap_ack !== 1'b0) begin
            $display("FAIL simul_pop got=%h/%0d/%b exp=0f0f0/0/0", bus.status_register,
                     bus.trap_depth, bus.trap_ack);
            failures++;
        end
        step();
        checks++;
        if (bus.trap_ack !== 1'b1) begin
            $display("FAIL simul_reack got=%b exp=1", bus.trap_ack);
            failures++;
        end
        bus.trap_req = 1'b0;
        step();
        checks++;
        if (bus.status_register !== 20'h7F0F0 || bus.trap_depth !== DEPTH_W'(1)) begin
            $display("FAIL simul_enter got=%h/%0d exp=7f0f0/1", bus.status_register, bus.trap_depth);
            failures++;
        end
        leave_trap();
    endtask

    task automatic test_underflow_swwrite();
        bus.trap_ret = 1'b1;
        step();
        bus.trap_ret = 1'b0;
        checks++;
        if (bus.err !== 2'b11 || bus.status_register !== 20'h0F0F0 || bus.trap_depth !== '0) begin
            $display("FAIL underflow got=%b/%h/%0d exp=11/0f0f0/0", bus.err, bus.status_register,
                     bus.trap_depth);
            failures++;
        end
        bus.sw_wr_en   = 1'b1;
        bus.sw_wr_data = 20'hFFFFF;
        step();
        bus.sw_wr_en = 1'b0;
        checks++;
        if (bus.status_register !== 20'hFFFFF) begin
            $display("FAIL swwr_idle got=%h exp=fffff", bus.status_register);
            failures++;
        end
        bus.trap_req   = 1'b1;
        bus.trap_cause = 4'h2;
        step();
        bus.trap_req   = 1'b0;
        bus.sw_wr_en   = 1'b1;
        bus.sw_wr_data = 20'h01234;
        step();
        bus.sw_wr_en = 1'b0;
        checks++;
        if (bus.status_register !== 20'h2FFFF || bus.trap_depth !== DEPTH_W'(1)) begin
            $display("FAIL swwr_enter got=%h/%0d exp=2ffff/1", bus.status_register, bus.trap_depth);
            failures++;
        end
        leave_trap();
    endtask

    task automatic test_random();
        bit               exp_mode;
        logic [DEPTH_W-1:0] exp_depth;
        clear_inputs();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.trap_ret     = ($urandom_range(0, 5) == 0);
            bus.xstat_commit = ($urandom_range(0, 3) == 0);
            bus.xstat_result = WIDTH'($urandom());
            bus.sw_wr_en     = ($urandom_range(0, 3) == 0);
            bus.sw_wr_data   = WIDTH'($urandom());
            if (bus.trap_req && bus.trap_ack) begin
                bus.trap_req = 1'b0;
            end else if (!bus.trap_req && !bus.trap_ack && $urandom_range(0, 2) == 0) begin
                bus.trap_req   = 1'b1;
                bus.trap_cause = CAUSE_W'($urandom());
            end
            step();
            exp_mode  = !m_entering && !m_returning && (m_stack.size() != 0);
            exp_depth = DEPTH_W'(m_stack.size());
            checks++;
            if (bus.status_register !== m_status || bus.trap_depth !== exp_depth ||
                bus.trap_mode !== exp_mode || bus.trap_ack !== m_entering || bus.err !== m_err) begin
                $display("FAIL random cyc=%0d got=%h/%0d/%b/%b/%b exp=%h/%0d/%b/%b/%b", cyc,
                         bus.status_register, bus.trap_depth, bus.trap_mode, bus.trap_ack, bus.err,
                         m_status, exp_depth, exp_mode, m_entering, m_err);
                failures++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_trap();
        test_commit_return();
        test_nesting_overflow();
        test_simultaneous();
        test_underflow_swwrite();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
